// File: rtl/countdown_timer_arbiter_pkg.sv
// Shared types and defaults for the countdown timer arbiter: FSM states,
// default sizing and the width of the round-robin pointer.
package countdown_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 16;

  // Wide enough for any legal requester count (up to 8).
  localparam int PTR_W = 3;

endpackage

// File: rtl/countdown_timer_arbiter_rr_pick.sv
// Combinational round-robin selector: scans req starting at ptr, wrapping
// NREQ-1 -> 0, and returns the first requester as one-hot and as an index.
module rr_pick
  import countdown_timer_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_vld
);

  always_comb begin : pick
    int idx;
    idx     = 0;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/countdown_timer_arbiter.sv
// Shared down-counter handed out round-robin to NREQ requesters; the owner
// holds grant for load+1 cycles and then receives a one-cycle done pulse.
module countdown_timer_arbiter
  import countdown_timer_arbiter_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;

  logic [NREQ-1:0]    pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [PTR_W-1:0]   ptr_after_owner;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign ptr_after_owner = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '1;
        grant_d = '0;
        if (pick_vld) begin
          state_d = ST_COUNT;
          grant_d = pick_oh;
          owner_d = pick_idx;
          count_d = load_val[int'(pick_idx)*WIDTH +: WIDTH];
        end
      end
      ST_COUNT: begin
        // Abort wins over completion, even when the counter already reads zero.
        if (abort) begin
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '1;
          ptr_d   = ptr_after_owner;
        end else if (count_q == '0) begin
          state_d = ST_DONE;
          grant_d = '0;
          done_d  = grant_q;
          count_d = '1;
          ptr_d   = ptr_after_owner;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '1;
      end
    endcase
  end

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '1;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_COUNT);
  assign count = count_q;

endmodule
